// File: rtl/i2c_target_rx.sv
// Write-only I2C target: oversamples sck/sda on clk, detects START/STOP, matches a 7-bit
// address, ACKs each byte and presents every received data byte as a one-clk strobe.
module i2c_target_rx #(
  parameter logic [6:0]  ADDR        = 7'h3C,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sck,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_first,
  output logic       busy
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_DATA     = 3'd3,
    ST_DATA_ACK = 3'd4,
    ST_IGNORE   = 3'd5
  } state_t;

  logic [SYNC_STAGES-1:0] sck_sync_r;
  logic [SYNC_STAGES-1:0] sda_sync_r;
  logic                   sck_d_r;
  logic                   sda_d_r;
  logic                   sck_now_s;
  logic                   sda_now_s;
  logic                   start_s;
  logic                   stop_s;
  logic                   rise_s;
  logic                   fall_s;
  logic                   addr_match_s;

  state_t     state_r;
  state_t     state_n;
  logic [2:0] cnt_r;
  logic [2:0] cnt_n;
  logic [7:0] shift_r;
  logic [7:0] shift_n;
  logic       done_r;
  logic       done_n;
  logic       armed_r;
  logic       armed_n;
  logic [7:0] rx_data_r;
  logic [7:0] rx_data_n;
  logic       rx_valid_r;
  logic       rx_valid_n;
  logic       rx_first_r;
  logic       rx_first_n;
  logic       sda_oe_r;
  logic       sda_oe_n;
  logic       busy_r;
  logic       busy_n;

  // Address byte is accepted only for our address with R/W = 0 (write).
  function automatic logic addr_match(input logic [7:0] frame, input logic [6:0] addr);
    return (frame[7:1] == addr) && (frame[0] == 1'b0);
  endfunction

  // Synchronisers plus one edge-detect stage; reset to the idle-bus level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sck_sync_r <= {SYNC_STAGES{1'b1}};
      sda_sync_r <= {SYNC_STAGES{1'b1}};
      sck_d_r    <= 1'b1;
      sda_d_r    <= 1'b1;
    end else begin
      sck_sync_r <= {sck_sync_r[SYNC_STAGES-2:0], sck};
      sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], sda_in};
      sck_d_r    <= sck_now_s;
      sda_d_r    <= sda_now_s;
    end
  end

  assign sck_now_s    = sck_sync_r[SYNC_STAGES-1];
  assign sda_now_s    = sda_sync_r[SYNC_STAGES-1];
  // sck must be high in both samples, so a simultaneous sck/sda change is plain data.
  assign start_s      = sck_now_s & sck_d_r & sda_d_r & ~sda_now_s;
  assign stop_s       = sck_now_s & sck_d_r & ~sda_d_r & sda_now_s;
  assign rise_s       = sck_now_s & ~sck_d_r;
  assign fall_s       = ~sck_now_s & sck_d_r;
  assign addr_match_s = addr_match(shift_r, ADDR);

  // FSM state, bit counter, shifter and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 3'd0;
      shift_r    <= 8'h00;
      done_r     <= 1'b0;
      armed_r    <= 1'b0;
      rx_data_r  <= 8'h00;
      rx_valid_r <= 1'b0;
      rx_first_r <= 1'b0;
      sda_oe_r   <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_n;
      cnt_r      <= cnt_n;
      shift_r    <= shift_n;
      done_r     <= done_n;
      armed_r    <= armed_n;
      rx_data_r  <= rx_data_n;
      rx_valid_r <= rx_valid_n;
      rx_first_r <= rx_first_n;
      sda_oe_r   <= sda_oe_n;
      busy_r     <= busy_n;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n    = state_r;
    cnt_n      = cnt_r;
    shift_n    = shift_r;
    done_n     = done_r;
    armed_n    = armed_r;
    rx_data_n  = rx_data_r;
    rx_valid_n = 1'b0;
    rx_first_n = 1'b0;

    if (start_s) begin
      state_n = ST_ADDR;
      cnt_n   = 3'd0;
      done_n  = 1'b0;
      armed_n = 1'b0;
    end else if (stop_s) begin
      state_n = ST_IDLE;
      cnt_n   = 3'd0;
      done_n  = 1'b0;
      armed_n = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_n = ST_IDLE;
        end
        ST_ADDR, ST_DATA: begin
          if (rise_s && !done_r) begin
            shift_n = {shift_r[6:0], sda_now_s};
            cnt_n   = cnt_r + 3'd1;
            done_n  = (cnt_r == 3'd7);
          end else if (fall_s && done_r) begin
            // Falling edge after bit 8: the ACK slot starts here.
            done_n = 1'b0;
            cnt_n  = 3'd0;
            if (state_r == ST_ADDR) begin
              state_n = addr_match_s ? ST_ADDR_ACK : ST_IGNORE;
            end else begin
              state_n    = ST_DATA_ACK;
              rx_data_n  = shift_r;
              rx_valid_n = 1'b1;
              rx_first_n = armed_r;
              armed_n    = 1'b0;
            end
          end else begin
            state_n = state_r;
          end
        end
        ST_ADDR_ACK: begin
          if (fall_s) begin
            state_n = ST_DATA;
            armed_n = 1'b1;
          end else begin
            state_n = ST_ADDR_ACK;
          end
        end
        ST_DATA_ACK: begin
          if (fall_s) begin
            state_n = ST_DATA;
          end else begin
            state_n = ST_DATA_ACK;
          end
        end
        ST_IGNORE: begin
          state_n = ST_IGNORE;
        end
        default: begin
          state_n = ST_IDLE;
          cnt_n   = 3'd0;
          done_n  = 1'b0;
          armed_n = 1'b0;
        end
      endcase
    end

    sda_oe_n = (state_n == ST_ADDR_ACK) || (state_n == ST_DATA_ACK);
    busy_n   = (state_n != ST_IDLE);
  end

  assign sda_oe   = sda_oe_r;
  assign rx_data  = rx_data_r;
  assign rx_valid = rx_valid_r;
  assign rx_first = rx_first_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_i2c_target_rx.sv
// Directed bench for i2c_target_rx: table of whole frames plus hand-written
// repeated-START and mid-byte reset sequences. sck half-period is 20 clk.
module tb_i2c_target_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sck;
  logic       sda_drv;
  logic       sda_bus;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_first;
  logic       busy;

  assign sda_bus = sda_drv & ~sda_oe;

  i2c_target_rx dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sck      (sck),
    .sda_in   (sda_bus),
    .sda_oe   (sda_oe),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_first (rx_first),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         ack_cnt  = 0;
  int         wide_cnt = 0;
  logic       oe_q     = 1'b0;
  logic       rv_q     = 1'b0;
  logic [8:0] rxq[$];

  // Monitor: counts ACK pulses and records every strobe as {first, data}.
  always @(negedge clk) begin
    if (sda_oe === 1'b1 && oe_q !== 1'b1) ack_cnt = ack_cnt + 1;
    if (rx_valid === 1'b1) begin
      rxq.push_back({rx_first, rx_data});
      if (rv_q === 1'b1) wide_cnt = wide_cnt + 1;
    end
    oe_q = sda_oe;
    rv_q = rx_valid;
  end

  typedef struct {
    int              nb;
    logic [3:0][7:0] b;
    int              acks;
    int              valids;
    logic [7:0]      d0;
    logic [7:0]      d1;
  } vec_t;

  vec_t vecs[5];

  function automatic vec_t mk(input int nb, input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3, input int acks,
                              input int valids, input logic [7:0] d0, input logic [7:0] d1);
    vec_t v;
    v.nb = nb; v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3;
    v.acks = acks; v.valids = valids; v.d0 = d0; v.d1 = d1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_start();
    clks(10); sda_drv = 1'b1;
    clks(10); sck = 1'b1;
    clks(20); sda_drv = 1'b0;
    clks(20); sck = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    clks(10); sda_drv = b;
    clks(10); sck = 1'b1;
    clks(20); sck = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    send_bit(1'b1);
  endtask

  task automatic send_stop();
    clks(10); sda_drv = 1'b0;
    clks(10); sck = 1'b1;
    clks(20); sda_drv = 1'b1;
    clks(20);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int a0;
    int q0;
    a0 = ack_cnt;
    q0 = rxq.size();
    send_start();
    chk($sformatf("v%0d_busy_in_frame", idx), busy, 1);
    for (int i = 0; i < v.nb; i++) send_byte(v.b[i]);
    send_stop();
    clks(5);
    chk($sformatf("v%0d_busy_after_stop", idx), busy, 0);
    chk($sformatf("v%0d_ack_count", idx), ack_cnt - a0, v.acks);
    chk($sformatf("v%0d_valid_count", idx), rxq.size() - q0, v.valids);
    if (v.valids >= 1 && rxq.size() > q0)
      chk($sformatf("v%0d_byte0", idx), rxq[q0], {1'b1, v.d0});
    if (v.valids >= 2 && rxq.size() > q0 + 1)
      chk($sformatf("v%0d_byte1", idx), rxq[q0 + 1], {1'b0, v.d1});
  endtask

  initial begin
    int a0;
    int q0;
    vecs[0] = mk(3, 8'h78, 8'h00, 8'hAF, 8'h00, 3, 2, 8'h00, 8'hAF);
    vecs[1] = mk(2, 8'h7A, 8'h55, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    vecs[2] = mk(2, 8'h79, 8'h12, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    vecs[3] = mk(2, 8'h78, 8'h40, 8'h00, 8'h00, 2, 1, 8'h40, 8'h00);
    vecs[4] = mk(4, 8'h78, 8'hC3, 8'h3C, 8'hFF, 4, 3, 8'hC3, 8'h3C);

    rst_n   = 1'b0;
    sck     = 1'b1;
    sda_drv = 1'b1;
    clks(4);
    chk("reset_sda_oe", sda_oe, 0);
    chk("reset_rx_valid", rx_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_rx_data", rx_data, 8'h00);
    chk("reset_rx_first", rx_first, 0);
    rst_n = 1'b1;
    clks(5);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // Repeated START after a partial data byte.
    a0 = ack_cnt;
    q0 = rxq.size();
    send_start();
    send_byte(8'h78);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    send_start();
    send_byte(8'h78);
    send_byte(8'hA5);
    send_stop();
    clks(5);
    chk("rstart_valid_count", rxq.size() - q0, 1);
    if (rxq.size() > q0) chk("rstart_byte", rxq[q0], {1'b1, 8'hA5});
    chk("rstart_ack_count", ack_cnt - a0, 3);

    // Reset in the middle of a data byte, then a fresh frame.
    send_start();
    send_byte(8'h78);
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    clks(2);
    rst_n = 1'b0;
    clks(1);
    chk("midrst_busy", busy, 0);
    chk("midrst_sda_oe", sda_oe, 0);
    clks(3);
    rst_n = 1'b1;
    a0 = ack_cnt;
    q0 = rxq.size();
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    send_bit(1'b1);
    send_stop();
    clks(5);
    chk("midrst_no_ack", ack_cnt - a0, 0);
    chk("midrst_no_valid", rxq.size() - q0, 0);
    chk("midrst_busy_idle", busy, 0);
    a0 = ack_cnt;
    q0 = rxq.size();
    send_start();
    send_byte(8'h78);
    send_byte(8'h8D);
    send_stop();
    clks(5);
    chk("postrst_ack_count", ack_cnt - a0, 2);
    chk("postrst_valid_count", rxq.size() - q0, 1);
    if (rxq.size() > q0) chk("postrst_byte", rxq[q0], {1'b1, 8'h8D});

    chk("valid_single_cycle", wide_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
